// File: rtl/spio_hss_multiplexer_pkt_arbiter_pkg.sv
// Shared constants for the HSS multiplexer packet arbiters: packet width,
// grant-counter width and the per-port slice macro for packed packet buses.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif
`ifndef SPIO_PKT_SLICE
`define SPIO_PKT_SLICE(idx, w) (idx)*(w) +: (w)
`endif

package spio_hss_multiplexer_pkt_arbiter_pkg;

  localparam int PKT_W_DEF    = `PKT_BITS;
  localparam int ARB_CNT_BITS = 16;
  localparam logic [ARB_CNT_BITS-1:0] ARB_CNT_MAX = '1;

  // Occupancy of the single output register.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/spio_rr_priority_select.sv
// Combinational round-robin priority select: starting at ptr_in and moving
// upward modulo N, the first valid port wins. Reusable by other arbiters.
module spio_rr_priority_select #(
  parameter int N        = 4,
  parameter int PTR_BITS = 2
) (
  input  logic [N-1:0]        vld_in,
  input  logic [PTR_BITS-1:0] ptr_in,
  output logic [N-1:0]        gnt_out,
  output logic [PTR_BITS-1:0] idx_out,
  output logic                any_out
);

  always_comb begin
    // NOTE: every output gets a default before any conditional assignment,
    // otherwise paths that skip an assignment infer a latch.
    gnt_out = '0;
    idx_out = '0;
    any_out = 1'b0;
    for (int off = 0; off < N; off++) begin
      for (int p = 0; p < N; p++) begin
        // p is the port sitting 'off' places above the pointer, modulo N.
        if (!any_out && vld_in[p] &&
            ((int'(ptr_in) + off == p) || (int'(ptr_in) + off - N == p))) begin
          gnt_out[p] = 1'b1;
          idx_out    = PTR_BITS'(p);
          any_out    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/spio_hss_multiplexer_pkt_arbiter.sv
// Round-robin whole-packet arbiter feeding the multiplexer's packet FIFO.
// Optional per-port grant counters are enabled by SPIO_PKT_ARB_STATS_EN.
`ifndef PKT_BITS
`define PKT_BITS 72
`endif
`ifndef SPIO_PKT_SLICE
`define SPIO_PKT_SLICE(idx, w) (idx)*(w) +: (w)
`endif

module spio_hss_multiplexer_pkt_arbiter
  import spio_hss_multiplexer_pkt_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int PTR_BITS  = 2,
  parameter int PKT_W     = `PKT_BITS
) (
  input  logic                       CLK_IN,
  input  logic                       RESET_IN,
  input  logic                       ENABLE_IN,
  input  logic [NUM_PORTS*PKT_W-1:0] REQ_DATA_IN,
  input  logic [NUM_PORTS-1:0]       REQ_VLD_IN,
  output logic [NUM_PORTS-1:0]       REQ_RDY_OUT,
  output logic [PKT_W-1:0]           ARB_DATA_OUT,
  output logic                       ARB_VLD_OUT,
  input  logic                       ARB_RDY_IN,
  output logic [PTR_BITS-1:0]        ARB_SRC_OUT,
  output logic                       ARB_IDLE_OUT
`ifdef SPIO_PKT_ARB_STATS_EN
  ,
  input  logic                              ARB_CNT_CLR_IN,
  output logic [NUM_PORTS*ARB_CNT_BITS-1:0] ARB_CNT_OUT
`endif
);

  out_state_e            state_q, state_d;
  logic [PKT_W-1:0]      data_q, data_d;
  logic [PTR_BITS-1:0]   src_q, src_d;
  logic [PTR_BITS-1:0]   ptr_q, ptr_d;
  logic                  post_rst_q;

  logic                  load_ok;
  logic                  grant_en;
  logic [NUM_PORTS-1:0]  cand;
  logic [NUM_PORTS-1:0]  gnt;
  logic [PTR_BITS-1:0]   win_idx;
  logic                  win_any;
  logic [PKT_W-1:0]      win_data;

  // Grants are suppressed in the reset cycle and the cycle right after it.
  assign load_ok  = (state_q == OUT_EMPTY) || ARB_RDY_IN;
  assign grant_en = ENABLE_IN && load_ok && !RESET_IN && !post_rst_q;
  assign cand     = grant_en ? REQ_VLD_IN : '0;

  spio_rr_priority_select #(
    .N        (NUM_PORTS),
    .PTR_BITS (PTR_BITS)
  ) u_select (
    .vld_in  (cand),
    .ptr_in  (ptr_q),
    .gnt_out (gnt),
    .idx_out (win_idx),
    .any_out (win_any)
  );

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt[i]) win_data = REQ_DATA_IN[`SPIO_PKT_SLICE(i, PKT_W)];
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      OUT_EMPTY: begin
        if (win_any) state_d = OUT_FULL;
      end
      OUT_FULL: begin
        if (!win_any && ARB_RDY_IN) state_d = OUT_EMPTY;
      end
      default: state_d = OUT_EMPTY;
    endcase
    // A grant implies load_ok, so loading never overwrites an unsent packet.
    if (win_any) begin
      data_d = win_data;
      src_d  = win_idx;
      ptr_d  = (win_idx == PTR_BITS'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK_IN) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RESET_IN) begin
      state_q    <= OUT_EMPTY;
      data_q     <= '0;
      src_q      <= '0;
      ptr_q      <= '0;
      post_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      src_q      <= src_d;
      ptr_q      <= ptr_d;
      post_rst_q <= 1'b0;
    end
  end

  assign REQ_RDY_OUT  = gnt;
  assign ARB_DATA_OUT = data_q;
  assign ARB_VLD_OUT  = (state_q == OUT_FULL);
  assign ARB_SRC_OUT  = src_q;
  assign ARB_IDLE_OUT = (state_q == OUT_EMPTY) && (!ENABLE_IN || (REQ_VLD_IN == '0));

`ifdef SPIO_PKT_ARB_STATS_EN
  logic [ARB_CNT_BITS-1:0] cnt_q [NUM_PORTS];
  logic [ARB_CNT_BITS-1:0] cnt_d [NUM_PORTS];

  // Saturating counters; a clear beats a same-cycle increment.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (ARB_CNT_CLR_IN) begin
        cnt_d[i] = '0;
      end else if (gnt[i] && (cnt_q[i] != ARB_CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    // NOTE: the counter array is small and architecturally visible, so it is
    // reset like ordinary flops rather than left to power-up contents.
    if (RESET_IN) begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    ARB_CNT_OUT = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      ARB_CNT_OUT[`SPIO_PKT_SLICE(i, ARB_CNT_BITS)] = cnt_q[i];
    end
  end
`endif

endmodule
